// File: rtl/seg_display_mux.sv
// Captures UART bytes as four hex nibbles and time-multiplexes them onto a shared
// seven-segment decoder with active-low digit anodes.
module seg_display_mux #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    input  logic       clear,
    output logic [3:0] nibble,
    output logic [3:0] anode,
    output logic [7:0] rx_count
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

    logic [15:0]     disp_q, disp_d;
    logic [1:0]      filled_q, filled_d;
    logic [1:0]      digit_idx_q, digit_idx_d;
    logic [CntW-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [7:0]      rx_count_q, rx_count_d;
    logic            refresh_wrap;
    logic            digit_en;

    assign refresh_wrap = (refresh_cnt_q == CntMax);

    always_comb begin
        disp_d        = disp_q;
        filled_d      = filled_q;
        rx_count_d    = rx_count_q;
        refresh_cnt_d = refresh_wrap ? '0 : refresh_cnt_q + 1'b1;
        digit_idx_d   = refresh_wrap ? digit_idx_q + 2'd1 : digit_idx_q;

        // Clear wins over a simultaneous strobe; the byte is dropped.
        if (clear) begin
            disp_d     = '0;
            filled_d   = '0;
            rx_count_d = '0;
        end else if (data_valid) begin
            disp_d     = {disp_q[7:0], data_in};
            filled_d   = (filled_q == 2'd2) ? 2'd2 : filled_q + 2'd1;
            rx_count_d = rx_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q        <= '0;
            filled_q      <= '0;
            digit_idx_q   <= '0;
            refresh_cnt_q <= '0;
            rx_count_q    <= '0;
        end else begin
            disp_q        <= disp_d;
            filled_q      <= filled_d;
            digit_idx_q   <= digit_idx_d;
            refresh_cnt_q <= refresh_cnt_d;
            rx_count_q    <= rx_count_d;
        end
    end

    // With one byte only digits 1..0 hold data.
    assign digit_en = (filled_q == 2'd2) || ((filled_q == 2'd1) && !digit_idx_q[1]);

    always_comb begin
        anode  = 4'b1111;
        nibble = 4'h0;
        if (digit_en) begin
            anode  = ~(4'b0001 << digit_idx_q);
            nibble = disp_q[{digit_idx_q, 2'b00} +: 4];
        end
    end

    assign rx_count = rx_count_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux: REFRESH_DIV=4 main instance plus a
// REFRESH_DIV=1 instance sharing the same inputs.
module tb_seg_display_mux;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] nibble, anode, nibble1, anode1;
    logic [7:0] rx_count, rx_count1;

    int n_checks = 0;
    int n_pass = 0;
    int n = 0;  // edges since the last reset edge

    seg_display_mux #(.REFRESH_DIV(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .clear      (clear),
        .nibble     (nibble),
        .anode      (anode),
        .rx_count   (rx_count)
    );

    seg_display_mux #(.REFRESH_DIV(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .clear      (clear),
        .nibble     (nibble1),
        .anode      (anode1),
        .rx_count   (rx_count1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        n = rst ? 0 : n + 1;
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        data_in    = b;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic goto_digit(input int d);
        for (int i = 0; i < 32 && ((n / 4) % 4) != d; i++) tick();
    endtask

    task automatic check_digit(input string tag, input int d, input logic [3:0] exp_an,
                               input logic [3:0] exp_nib);
        goto_digit(d);
        check({tag, "_anode"}, {4'h0, anode}, {4'h0, exp_an});
        check({tag, "_nibble"}, {4'h0, nibble}, {4'h0, exp_nib});
    endtask

    initial begin
        // 1. Reset
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_anode", {4'h0, anode}, 8'h0F);
        check("rst_nibble", {4'h0, nibble}, 8'h00);
        check("rst_rx_count", rx_count, 8'h00);
        check("rst_anode_div1", {4'h0, anode1}, 8'h0F);
        repeat (5) tick();
        check("empty_scan_anode", {4'h0, anode}, 8'h0F);

        // 2. Single byte
        send_byte(8'hA5);
        check("one_rx_count", rx_count, 8'd1);
        check_digit("one_d0", 0, 4'b1110, 4'h5);
        check_digit("one_d1", 1, 4'b1101, 4'hA);
        check_digit("one_d2", 2, 4'b1111, 4'h0);
        check_digit("one_d3", 3, 4'b1111, 4'h0);

        // 3. Two bytes, then a third (after a clear so rx_count restarts)
        clear = 1'b1;
        tick();
        clear = 1'b0;
        send_byte(8'h3C);
        send_byte(8'h7E);
        check_digit("two_d0", 0, 4'b1110, 4'hE);
        check_digit("two_d1", 1, 4'b1101, 4'h7);
        check_digit("two_d2", 2, 4'b1011, 4'hC);
        check_digit("two_d3", 3, 4'b0111, 4'h3);
        send_byte(8'h01);
        check("three_rx_count", rx_count, 8'd3);
        check_digit("three_d0", 0, 4'b1110, 4'h1);
        check_digit("three_d1", 1, 4'b1101, 4'h0);
        check_digit("three_d2", 2, 4'b1011, 4'hE);
        check_digit("three_d3", 3, 4'b0111, 4'h7);

        // 4. Clear collides with a strobe
        data_in    = 8'hFF;
        data_valid = 1'b1;
        clear      = 1'b1;
        tick();
        data_valid = 1'b0;
        clear      = 1'b0;
        check("clr_rx_count", rx_count, 8'd0);
        for (int d = 0; d < 4; d++) check_digit("clr_blank", d, 4'b1111, 4'h0);
        send_byte(8'h5A);
        check_digit("clr_timing_d1", 1, 4'b1101, 4'h5);
        check_digit("clr_timing_d0", 0, 4'b1110, 4'hA);

        // 5. 256 bytes wrap rx_count; last two are A4, A5
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 256; i++) send_byte(8'(i) ^ 8'h5A);
        check("wrap_rx_count", rx_count, 8'd0);
        check_digit("wrap_d0", 0, 4'b1110, 4'h5);
        check_digit("wrap_d1", 1, 4'b1101, 4'hA);
        check_digit("wrap_d2", 2, 4'b1011, 4'h4);
        check_digit("wrap_d3", 3, 4'b0111, 4'hA);

        // 6. Reset at refresh_cnt=2 of digit 2
        goto_digit(2);
        for (int i = 0; i < 8 && (n % 4) != 2; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_anode", {4'h0, anode}, 8'h0F);
        check("mid_rst_rx_count", rx_count, 8'd0);
        send_byte(8'h12);  // edge n=1
        check("restart_n1_anode", {4'h0, anode}, 8'h0E);
        check("restart_n1_nibble", {4'h0, nibble}, 8'h02);
        check("div1_n1_anode", {4'h0, anode1}, 8'h0D);
        check("div1_n1_nibble", {4'h0, nibble1}, 8'h01);
        send_byte(8'h34);  // edge n=2, display 1234
        check("restart_n2_anode", {4'h0, anode}, 8'h0E);
        check("restart_n2_nibble", {4'h0, nibble}, 8'h04);
        check("div1_n2_anode", {4'h0, anode1}, 8'h0B);
        check("div1_n2_nibble", {4'h0, nibble1}, 8'h02);
        tick();            // n=3
        check("restart_n3_anode", {4'h0, anode}, 8'h0E);
        check("div1_n3_anode", {4'h0, anode1}, 8'h07);
        check("div1_n3_nibble", {4'h0, nibble1}, 8'h01);
        tick();            // n=4
        check("restart_n4_anode", {4'h0, anode}, 8'h0D);
        check("restart_n4_nibble", {4'h0, nibble}, 8'h03);
        check("div1_n4_anode", {4'h0, anode1}, 8'h0E);
        check("div1_n4_nibble", {4'h0, nibble1}, 8'h04);
        tick();            // n=5
        check("div1_n5_anode", {4'h0, anode1}, 8'h0D);
        check("div1_rx_count", rx_count1, 8'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_display_mux.md
Name: seg_display_mux

Overview:
- Upstream feeder for the hex seven-segment decoder on the 4-digit board display.
- Captures bytes received by the UART RX path and keeps the last two bytes as four hex nibbles.
- Time-multiplexes the nibbles onto the shared decoder input (w,x,y,z) and drives the active-low digit anodes.
- Also keeps a running count of accepted bytes for debug LEDs.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit stays lit; legal range >= 1; counter width = clog2(REFRESH_DIV), minimum 1 bit.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
data_in  input  8  received byte from UART RX
data_valid  input  1  one-cycle strobe; data_in is valid in the same cycle
clear  input  1  synchronous display clear (user button, already debounced)
nibble  output  4  hex digit to the decoder; nibble[3]=w (MSB), [2]=x, [1]=y, [0]=z
anode  output  4  active-low digit enables; anode[0] is the rightmost digit
rx_count  output  8  number of bytes accepted, modulo 256

Behaviour:
State registers:
- disp_reg[15:0]
- filled[1:0], range 0..2
- digit_idx[1:0]
- refresh_cnt
- rx_count[7:0]

Reset (rst=1 at a clock edge):
- All state registers clear to 0.
- Outputs the cycle after: anode=4'b1111, nibble=4'h0, rx_count=0.
- rst overrides clear and data_valid.

Capture:
- A clock edge with data_valid=1 and clear=0 applies all of the following:
  - disp_reg <= {disp_reg[7:0], data_in}; the older byte moves to digits 3..2 and the new byte goes to digits 1..0.
  - filled <= min(filled+1, 2).
  - rx_count <= rx_count+1, wrapping 255->0.
- data_valid is a strobe with no backpressure; every strobe is accepted.
- Capture latency: the new value is visible on nibble in the first cycle after the capture edge, if the current digit is enabled.

Clear:
- clear=1 at an edge sets disp_reg=0, filled=0, rx_count=0.
- clear does not touch refresh_cnt or digit_idx.
- clear and data_valid in the same cycle: clear wins and the byte is dropped (rx_count=0).

Refresh:
- refresh_cnt counts 0..REFRESH_DIV-1, then wraps to 0.
- On the wrap edge, digit_idx <= digit_idx+1 (mod 4, 3->0).
- With REFRESH_DIV=1, digit_idx advances every cycle.
- Refresh runs continuously regardless of filled, clear, or data_valid.

Output decode (combinational from registers only; no input-to-output path):
- Digit i selects disp_reg[4i+3:4i].
- Digit i is enabled when filled=2, or when filled=1 and i<=1.
- Enabled digit: anode = ~(1<<digit_idx), nibble = selected digit value.
- Blanked digit: anode=4'b1111, nibble=4'h0.
- Exactly one anode is low at any time, or none.

Boundary cases:
- filled saturates at 2; later bytes keep shifting.
- A rst asserted mid-refresh restarts the scan at digit 0 with a full REFRESH_DIV period.

Test Plan:
All tests use REFRESH_DIV=4.
1. Reset: hold rst for 3 cycles, then release -> anode=1111, nibble=0, rx_count=0. digit_idx advances after 4 cycles, but anode stays 1111 because filled=0.
2. Single byte: pulse data_valid with data_in=8'hA5 -> rx_count=1.
   - Digit 0 slot: anode=1110, nibble=5.
   - Digit 1 slot: anode=1101, nibble=A.
   - Digit 2 and 3 slots: anode=1111, nibble=0.
3. Two bytes: send 8'h3C, then 8'h7E -> the four slots show nibble E,7,C,3 with anodes 1110,1101,1011,0111. A third byte 8'h01 gives 1,0,E,7 and rx_count=3.
4. Clear collision: assert clear and data_valid (data_in=8'hFF) in the same cycle -> rx_count=0, all anodes 1111, and the scan timing is unaffected.
5. Wrap: send 256 bytes -> rx_count=0. Display shows the last two bytes, and filled stays at 2.
6. Reset mid-operation: assert rst at refresh_cnt=2 of digit 2 -> next cycle anode=1111, and after release digit 0 lasts exactly 4 cycles. Also run with REFRESH_DIV=1 and confirm digit_idx changes every cycle.
